// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encodings, default sizing and the byte-insertion helper used by the
// word assembler.
package imem_loader_pkg;

    localparam int IMEM_DEFAULT_MAX_WORDS = 1024;
    localparam int IMEM_DATA_WIDTH        = 32;

    typedef enum logic [1:0] {
        IMEM_LD_LEN   = 2'd0,
        IMEM_LD_LOAD  = 2'd1,
        IMEM_LD_DONE  = 2'd2,
        IMEM_LD_ERROR = 2'd3
    } imem_ld_state_e;

    // Shift a new byte in at the top; after four insertions the first byte
    // received sits in bits [7:0] (little-endian assembly).
    function automatic logic [31:0] word_insert_byte(input logic [31:0] word,
                                                     input logic [7:0]  byte_in);
        return {byte_in, word[31:8]};
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four accepted bytes into a little-endian 32-bit word. The same
// instance serves the length header and every data word, since both share
// the 4-byte little-endian framing.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [31:0] shift_q;
    logic [31:0] shift_d;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;

    // Next-state: insert the accepted byte and advance the byte position.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (byte_valid_i) begin
            shift_d = word_insert_byte(shift_q, byte_i);
            cnt_d   = cnt_q + 2'd1;
        end else begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
        end
    end

    // Byte shift register and position counter; reset discards a partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= 32'd0;
            cnt_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // The completed word is presented in the same cycle as its 4th byte so
    // the loader can register it without an extra pipeline stage.
    assign word_o      = shift_d;
    assign word_done_o = byte_valid_i & (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed little-endian byte stream and
// writes it into the instruction BRAM, holding the core's PC stalled until
// the whole program is in place.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS  = IMEM_DEFAULT_MAX_WORDS,
    parameter int DATA_WIDTH = IMEM_DATA_WIDTH
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_dat,
    output logic                  w_enb,
    output logic                  cpu_stall,
    output logic                  load_done,
    output logic                  err
);

    // One extra bit so the index can hold MAX_WORDS itself and never wraps.
    localparam int          IDX_W       = $clog2(MAX_WORDS) + 1;
    localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

    imem_ld_state_e          state_q;
    imem_ld_state_e          state_d;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic [IDX_W-1:0]        n_q;
    logic [IDX_W-1:0]        n_d;
    logic                    w_enb_q;
    logic                    w_enb_d;
    logic [DATA_WIDTH-1:0]   w_addr_q;
    logic [DATA_WIDTH-1:0]   w_addr_d;
    logic [DATA_WIDTH-1:0]   w_dat_q;
    logic [DATA_WIDTH-1:0]   w_dat_d;
    logic                    cpu_stall_q;
    logic                    load_done_q;
    logic                    err_q;

    logic                    accept_s;
    logic [31:0]             asm_word_s;
    logic                    asm_done_s;

    // Bytes are taken only while receiving the header or data, and never
    // while reset is held.
    assign rx_ready = ~rst & ((state_q == IMEM_LD_LEN) | (state_q == IMEM_LD_LOAD));
    assign accept_s = rx_valid & rx_ready;

    word_assembler u_word_asm (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (accept_s),
        .byte_i       (rx_data),
        .word_o       (asm_word_s),
        .word_done_o  (asm_done_s)
    );

    // Next-state and write-port decode for the load sequence.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        w_enb_d  = 1'b0;
        w_addr_d = w_addr_q;
        w_dat_d  = w_dat_q;
        case (state_q)
            IMEM_LD_LEN: begin
                if (asm_done_s) begin
                    if (asm_word_s == 32'd0) begin
                        state_d = IMEM_LD_DONE;
                    end else if (asm_word_s > MAX_WORDS_W) begin
                        state_d = IMEM_LD_ERROR;
                    end else begin
                        n_d     = asm_word_s[IDX_W-1:0];
                        state_d = IMEM_LD_LOAD;
                    end
                end else begin
                    state_d = IMEM_LD_LEN;
                end
            end
            IMEM_LD_LOAD: begin
                if (asm_done_s) begin
                    w_enb_d  = 1'b1;
                    w_dat_d  = DATA_WIDTH'(asm_word_s);
                    w_addr_d = DATA_WIDTH'({idx_q, 2'b00});
                    idx_d    = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    // Leave LOAD together with the final write strobe.
                    if (idx_d == n_q) begin
                        state_d = IMEM_LD_DONE;
                    end else begin
                        state_d = IMEM_LD_LOAD;
                    end
                end else begin
                    state_d = IMEM_LD_LOAD;
                end
            end
            IMEM_LD_DONE: begin
                state_d = IMEM_LD_DONE;
            end
            IMEM_LD_ERROR: begin
                state_d = IMEM_LD_ERROR;
            end
            default: begin
                // Unreachable encoding: park in the stalled error state.
                state_d = IMEM_LD_ERROR;
            end
        endcase
    end

    // State, counters, write port and core-control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IMEM_LD_LEN;
            idx_q       <= '0;
            n_q         <= '0;
            w_enb_q     <= 1'b0;
            w_addr_q    <= '0;
            w_dat_q     <= '0;
            cpu_stall_q <= 1'b1;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            w_enb_q     <= w_enb_d;
            w_addr_q    <= w_addr_d;
            w_dat_q     <= w_dat_d;
            // Release lags DONE entry by a cycle so the last write lands
            // before the core's first fetch.
            cpu_stall_q <= (state_q != IMEM_LD_DONE);
            load_done_q <= (state_q == IMEM_LD_DONE);
            err_q       <= (state_d == IMEM_LD_ERROR);
        end
    end

    assign w_enb     = w_enb_q;
    assign w_addr    = w_addr_q;
    assign w_dat     = w_dat_q;
    assign cpu_stall = cpu_stall_q;
    assign load_done = load_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (MAX_WORDS = 1024).
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [31:0] w_addr;
    logic [31:0] w_dat;
    logic        w_enb;
    logic        cpu_stall;
    logic        load_done;
    logic        err;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int last_cyc;
    int rdy_miss;
    int ld_cyc  = -1;
    int st_cyc  = -1;
    logic ld_prev = 1'b0;
    logic st_prev = 1'b1;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_dat[$];
    int          wq_cyc[$];

    imem_loader #(.MAX_WORDS(1024), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .w_addr    (w_addr),
        .w_dat     (w_dat),
        .w_enb     (w_enb),
        .cpu_stall (cpu_stall),
        .load_done (load_done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter, stepped at each active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log write strobes and release edges, sampled mid-cycle.
    always @(negedge clk) begin
        if (w_enb === 1'b1) begin
            wq_addr.push_back(w_addr);
            wq_dat.push_back(w_dat);
            wq_cyc.push_back(cyc);
        end
        if (load_done === 1'b1 && !ld_prev) ld_cyc <= cyc;
        ld_prev <= (load_done === 1'b1);
        if (cpu_stall === 1'b0 && st_prev) st_cyc <= cyc;
        st_prev <= (cpu_stall !== 1'b0);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wa(input int i);
        return (i < wq_addr.size()) ? wq_addr[i] : 32'hDEAD_DEAD;
    endfunction
    function automatic logic [31:0] wd(input int i);
        return (i < wq_dat.size()) ? wq_dat[i] : 32'hDEAD_DEAD;
    endfunction
    function automatic int wc(input int i);
        return (i < wq_cyc.size()) ? wq_cyc[i] : -100;
    endfunction

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Present one byte for one cycle; it must be accepted at the next edge.
    task automatic send_byte(input logic [7:0] b);
        if (rx_ready !== 1'b1) rdy_miss++;
        rx_valid = 1'b1;
        rx_data  = b;
        last_cyc = cyc;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        logic [31:0] t;
        t = w;
        for (int k = 0; k < 4; k++) begin
            if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
            send_byte(t[7:0]);
            t = t >> 8;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("rst_rx_ready",  {31'd0, rx_ready},  32'd0);
        check_eq("rst_w_enb",     {31'd0, w_enb},     32'd0);
        check_eq("rst_cpu_stall", {31'd0, cpu_stall}, 32'd1);
        check_eq("rst_load_done", {31'd0, load_done}, 32'd0);
        check_eq("rst_err",       {31'd0, err},       32'd0);
        rst = 1'b0;
        #1;
        check_eq("rdy_after_rst", {31'd0, rx_ready}, 32'd1);
        rdy_miss = 0;
    endtask

    initial begin
        int base;
        int bad_words;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

        // Two back-to-back words.
        do_reset();
        base = wq_addr.size();
        send_word(32'd2, 0);
        send_word(32'h0050_0013, 0);
        send_word(32'h00A0_0093, 0);
        idle(4); #1;
        check_eq("t1_nwrites", 32'(wq_addr.size() - base), 32'd2);
        check_eq("t1_addr0", wa(base),     32'h0);
        check_eq("t1_dat0",  wd(base),     32'h0050_0013);
        check_eq("t1_addr1", wa(base + 1), 32'h4);
        check_eq("t1_dat1",  wd(base + 1), 32'h00A0_0093);
        check_eq("t1_spacing", 32'(wc(base + 1) - wc(base)), 32'd4);
        check_eq("t1_wr_lat", 32'(wc(base + 1)), 32'(last_cyc + 1));
        check_eq("t1_done_cyc",  32'(ld_cyc), 32'(wc(base + 1) + 1));
        check_eq("t1_stall_cyc", 32'(st_cyc), 32'(wc(base + 1) + 1));
        check_eq("t1_rx_ready",  {31'd0, rx_ready}, 32'd0);
        check_eq("t1_rdy_miss",  32'(rdy_miss), 32'd0);

        // Zero-length program.
        do_reset();
        base = wq_addr.size();
        send_word(32'd0, 0);
        idle(4); #1;
        check_eq("t2_nwrites", 32'(wq_addr.size() - base), 32'd0);
        check_eq("t2_done_cyc", 32'(ld_cyc), 32'(last_cyc + 2));
        check_eq("t2_load_done", {31'd0, load_done}, 32'd1);
        check_eq("t2_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        check_eq("t2_rx_ready", {31'd0, rx_ready}, 32'd0);

        // Oversized header: N = 1025.
        do_reset();
        base = wq_addr.size();
        send_word(32'd1025, 0);
        idle(3); #1;
        check_eq("t3_err", {31'd0, err}, 32'd1);
        check_eq("t3_cpu_stall", {31'd0, cpu_stall}, 32'd1);
        check_eq("t3_load_done", {31'd0, load_done}, 32'd0);
        rdy_miss = 0;
        for (int k = 0; k < 6; k++) begin
            if (rx_ready !== 1'b0) rdy_miss++;
            rx_valid = 1'b1;
            rx_data  = 8'h55;
            @(negedge clk);
        end
        idle(2); #1;
        check_eq("t3_rx_ready_hi", 32'(rdy_miss), 32'd0);
        check_eq("t3_nwrites", 32'(wq_addr.size() - base), 32'd0);
        check_eq("t3_err_sticky", {31'd0, err}, 32'd1);

        // N = 1 with random idle gaps between bytes.
        do_reset();
        base = wq_addr.size();
        send_word(32'd1, 5);
        send_word(32'hDEAD_BEEF, 5);
        idle(4); #1;
        check_eq("t4_nwrites", 32'(wq_addr.size() - base), 32'd1);
        check_eq("t4_addr", wa(base), 32'h0);
        check_eq("t4_dat",  wd(base), 32'hDEAD_BEEF);
        check_eq("t4_load_done", {31'd0, load_done}, 32'd1);
        check_eq("t4_rdy_miss", 32'(rdy_miss), 32'd0);

        // Reset during word 3, then a fresh single-word load.
        do_reset();
        base = wq_addr.size();
        send_word(32'd5, 0);
        send_word(32'h1111_1111, 0);
        send_word(32'h2222_2222, 0);
        send_word(32'h3333_3333, 0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("t5_nwrites_pre", 32'(wq_addr.size() - base), 32'd3);
        check_eq("t5_addr2", wa(base + 2), 32'h8);
        check_eq("t5_cpu_stall", {31'd0, cpu_stall}, 32'd1);
        do_reset();
        base = wq_addr.size();
        send_word(32'd1, 0);
        send_word(32'h4433_2211, 0);
        idle(4); #1;
        check_eq("t5_nwrites_post", 32'(wq_addr.size() - base), 32'd1);
        check_eq("t5_addr", wa(base), 32'h0);
        check_eq("t5_dat",  wd(base), 32'h4433_2211);

        // Full-capacity load.
        do_reset();
        base = wq_addr.size();
        send_word(32'd1024, 0);
        for (int i = 0; i < 1024; i++) send_word(32'h1000_0000 + 32'(i), 0);
        idle(4); #1;
        check_eq("t6_nwrites", 32'(wq_addr.size() - base), 32'd1024);
        bad_words = 0;
        for (int i = 0; i < 1024; i++) begin
            if (wa(base + i) !== 32'(4 * i) || wd(base + i) !== 32'h1000_0000 + 32'(i))
                bad_words++;
        end
        check_eq("t6_bad_words", 32'(bad_words), 32'd0);
        check_eq("t6_last_addr", wa(base + 1023), 32'h0000_0FFC);
        check_eq("t6_done_cyc", 32'(ld_cyc), 32'(wc(base + 1023) + 1));
        check_eq("t6_load_done", {31'd0, load_done}, 32'd1);
        check_eq("t6_err", {31'd0, err}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
